fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Consumer-side adapter that drains the shift-style `fifo`. That FIFO has a registered read port: data appears one cycle after `read_en` and holds until the next pop.
- This block pops the FIFO, tracks the in-flight read, and captures returning data into a small circular skid buffer.
- It presents the data downstream as a valid/ready stream, for example fetch-queue to decode, at full throughput.
- A synchronous flush discards buffered and in-flight entries for branch-mispredict recovery.

Parameters:
- T, logic [31:0], payload type; must match the FIFO's T.
- DEPTH, 2, skid buffer entries; legal range 2..16, need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all buffered and in-flight data.
- fifo_empty  input  1  from the FIFO's `empty` output.
- fifo_read_data  input  $bits(T)  from the FIFO's `read_data` output; valid only in the cycle after a pop.
- fifo_read_en  output  1  pop request to the FIFO.
- out_valid  output  1  `out_data` holds a valid entry.
- out_data  output  $bits(T)  head entry of the buffer.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- out_count  output  $clog2(DEPTH+1)  number of entries currently buffered.

Behaviour:
- Reset (reset=0, asynchronous): count, head, tail and inflight cleared; buffer contents cleared to '0.
  - All outputs 0 while reset is low and until the first clk edge after release.
- State:
  - buf[DEPTH], circular buffer.
  - head and tail pointers; each wraps from DEPTH-1 to 0.
  - count, 0..DEPTH.
  - inflight, 1 bit: a pop issued last cycle whose data returns this cycle.
- pop = out_valid && out_ready.
- out_valid = (count != 0); out_data = buf[head]; out_count = count. All are combinational from registers only.
- fifo_read_en = !fifo_empty && !flush && (count + inflight - pop) < DEPTH.
  - This is the only combinational path from `out_ready` to `fifo_read_en`.
  - It guarantees that no returning datum is ever dropped for lack of space.
- inflight <= fifo_read_en, registered every cycle; it is cleared by flush.
- Capture: in any cycle with inflight=1 and flush=0, buf[tail] <= fifo_read_data and tail advances.
- Count update:
  - capture only: +1.
  - pop only: -1.
  - capture and pop in the same cycle: count unchanged, head and tail both advance.
- Pop: head advances with wrap; buffer contents are not cleared.
- Latency: FIFO non-empty at cycle N with the buffer empty → fifo_read_en at N → data captured at the N+1 edge → out_valid=1 in cycle N+2.
- Throughput: one entry per cycle sustained when out_ready=1 continuously and the FIFO stays non-empty, with DEPTH=2.
- Flush (synchronous, takes priority over everything):
  - count, head, tail and inflight go to 0 at the edge.
  - fifo_read_en=0 during the flush cycle.
  - Any datum returning in the flush cycle is discarded.
  - out_valid may still be 1 during the flush cycle. A pop in that cycle counts as accepted downstream, but internal state is cleared regardless.
- Backpressure: if out_ready=0 and the buffer is full with nothing in flight, fifo_read_en=0 and the FIFO keeps its contents.
- fifo_empty=1: no pop is issued; an in-flight datum still completes its capture.
- Order is preserved: out_data follows the FIFO pop order exactly.
- Assertions, for the bench:
  - count never exceeds DEPTH.
  - No capture occurs when count == DEPTH without a simultaneous pop.
  - fifo_read_en is never high while fifo_empty=1.

Test Plan:
- Reset mid-stream: assert reset=0 with count=2 and inflight=1 → out_valid, out_count and fifo_read_en are 0 immediately; after release the first pushed word 0xA5 appears as out_data two cycles after fifo_read_en.
- Streaming: FIFO preloaded with 0x1..0x8, out_ready=1 held → fifo_read_en high for 8 consecutive cycles; out_data sequence 0x1..0x8 on 8 consecutive cycles starting 2 cycles after the first pop; out_count stays ≤1.
- Backpressure: 5 words 0x10..0x14, out_ready=0 → exactly 2 pops and out_count=2, with 0x10 held on out_data. Then raise out_ready → 0x10..0x14 delivered in order with no gaps or duplicates.
- Simultaneous capture and pop at full occupancy (count=2, inflight=1, out_ready=1) → count stays 2, head and tail advance, and the next word is accepted without loss. Run with DEPTH=3 to exercise wrap at index 2→0.
- Flush with an in-flight read: pop 0x55 at cycle N, flush at N+1 while count=1 → out_count=0 and out_valid=0 at N+2; 0x55 never appears downstream; the next FIFO word 0x66 is delivered normally.
- Empty FIFO: fifo_empty=1 for 10 cycles → fifo_read_en stays 0 and out_valid stays 0. A word pushed at cycle 10 is delivered by cycle 13 at the latest.

Source files
------------

// File: rtl/fifo_reader.sv
// Consumer-side adapter for a FIFO with a registered read port: pops it, tracks the
// in-flight read and presents the returned words as a valid/ready stream via a skid buffer.
`timescale 1ns/1ps
module fifo_reader #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         fifo_empty,
    input  T                             fifo_read_data,
    output logic                         fifo_read_en,
    output logic                         out_valid,
    output T                             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int PW = $clog2(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    T              r_buf [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    // Holds fifo_read_en low until the first clock edge after reset release.
    logic          r_run;

    logic          w_pop;
    logic          w_capture;
    logic [OW-1:0] w_occ;
    logic          w_read_en;

    always_comb begin
        w_pop     = (r_count != '0) && out_ready;
        w_capture = r_inflight && !flush;
        // Occupancy once this cycle's pop and returning datum settle; w_pop implies count >= 1.
        w_occ     = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
        w_read_en = r_run && !fifo_empty && !flush && (w_occ < OW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_run      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_read_en;
                if (w_capture) begin
                    r_buf[r_tail] <= fifo_read_data;
                    r_tail        <= ptr_inc(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptr_inc(r_head);
                end
                case ({w_capture, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign fifo_read_en = w_read_en;
    assign out_valid    = (r_count != '0);
    assign out_data     = r_buf[r_head];
    assign out_count    = r_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: DEPTH=2 instance driven from a vector table,
// DEPTH=3 instance exercised by hand-written wrap and mid-stream reset sequences.
`timescale 1ns/1ps
module tb_fifo_reader;

    typedef struct {
        int          rep;
        int          npush;
        logic [31:0] pw;
        logic        rdy;
        logic        fl;
        logic        re;
        logic        v;
        logic [31:0] d;
        logic [1:0]  c;
    } vec_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        flush_a, flush_b;
    logic        empty_a, empty_b;
    logic [31:0] rdata_a, rdata_b;
    logic        rd_en_a, rd_en_b;
    logic        ovalid_a, ovalid_b;
    logic [31:0] odata_a, odata_b;
    logic        oready_a, oready_b;
    logic [1:0]  ocount_a, ocount_b;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    vec_t        tbl[$];
    int          nvec = 0;
    int          nerr = 0;

    fifo_reader #(.T(logic [31:0]), .DEPTH(2)) dut_a (
        .clk(clk), .reset(rst_a), .flush(flush_a), .fifo_empty(empty_a),
        .fifo_read_data(rdata_a), .fifo_read_en(rd_en_a), .out_valid(ovalid_a),
        .out_data(odata_a), .out_ready(oready_a), .out_count(ocount_a)
    );

    fifo_reader #(.T(logic [31:0]), .DEPTH(3)) dut_b (
        .clk(clk), .reset(rst_b), .flush(flush_b), .fifo_empty(empty_b),
        .fifo_read_data(rdata_b), .fifo_read_en(rd_en_b), .out_valid(ovalid_b),
        .out_data(odata_b), .out_ready(oready_b), .out_count(ocount_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic re_a, input logic v_a,
                           input logic [31:0] d_a, input logic [1:0] c_a,
                           input logic re, input logic v, input logic [31:0] d,
                           input logic [1:0] c);
        chk({tag, "_read_en"}, 32'(re_a), 32'(re));
        chk({tag, "_valid"}, 32'(v_a), 32'(v));
        chk({tag, "_count"}, 32'(c_a), 32'(c));
        if (v) chk({tag, "_data"}, d_a, d);
    endtask

    // One clock: invariant checks, the edge, then the FIFO models' registered read port.
    task automatic tick();
        logic pa, pb;
        chk("inv_a_pop_while_empty", 32'(rd_en_a & empty_a), 32'd0);
        chk("inv_b_pop_while_empty", 32'(rd_en_b & empty_b), 32'd0);
        chk("inv_a_count_le_depth", 32'(ocount_a > 2'd2), 32'd0);
        pa = rd_en_a;
        pb = rd_en_b;
        @(posedge clk);
        #1;
        if (pa) rdata_a = qa.pop_front();
        if (pb) rdata_b = qb.pop_front();
        empty_a = (qa.size() == 0);
        empty_b = (qb.size() == 0);
        @(negedge clk);
    endtask

    task automatic bstep(input string tag, input logic rdy, input logic re, input logic v,
                         input logic [31:0] d, input logic [1:0] c);
        oready_b = rdy;
        #1;
        chk_out(tag, rd_en_b, ovalid_b, odata_b, ocount_b, re, v, d, c);
        tick();
    endtask

    task automatic add(input int rep, input int npush, input logic [31:0] pw, input logic rdy,
                       input logic fl, input logic re, input logic v, input logic [31:0] d,
                       input logic [1:0] c);
        vec_t t;
        t.rep = rep; t.npush = npush; t.pw = pw; t.rdy = rdy; t.fl = fl;
        t.re = re; t.v = v; t.d = d; t.c = c;
        tbl.push_back(t);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        empty_a = 1'b1; empty_b = 1'b1;
        rdata_a = '0; rdata_b = '0;
        oready_a = 1'b0; oready_b = 1'b0;

        //        rep np  pw     rdy fl  re v  d      c
        // streaming 0x1..0x8
        add(1,  8, 32'h1,  1, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 1, 0, 32'h0,  0);
        for (int k = 1; k <= 6; k++) add(1, 0, 32'h0, 1, 0, 1, 1, 32'(k), 1);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h7,  1);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h8,  1);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        // backpressure 0x10..0x14
        add(1,  5, 32'h10, 0, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 0, 0, 1, 32'h10, 1);
        add(2,  0, 32'h0,  0, 0, 0, 1, 32'h10, 2);
        add(1,  0, 32'h0,  1, 0, 1, 1, 32'h10, 2);
        add(1,  0, 32'h0,  1, 0, 1, 1, 32'h11, 1);
        add(1,  0, 32'h0,  1, 0, 1, 1, 32'h12, 1);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h13, 1);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h14, 1);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        // flush with 0x55 in flight
        add(1,  2, 32'h54, 0, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 1, 0, 1, 32'h54, 1);
        add(1,  1, 32'h66, 1, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h66, 1);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        // flush blocks a pop from a non-empty FIFO
        add(1,  1, 32'h70, 0, 1, 0, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  0, 0, 0, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h70, 1);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        // empty FIFO for 10 cycles, then 0x77
        add(10, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        add(1,  1, 32'h77, 1, 0, 1, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);
        add(1,  0, 32'h0,  1, 0, 0, 1, 32'h77, 1);
        add(1,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0);

        #1;
        chk_out("rst_a", rd_en_a, ovalid_a, odata_a, ocount_a, 0, 0, 32'h0, 0);
        chk("rst_a_data", odata_a, 32'h0);
        chk_out("rst_b", rd_en_b, ovalid_b, odata_b, ocount_b, 0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].rep; r++) begin
                if (r == 0 && tbl[k].npush > 0) begin
                    for (int j = 0; j < tbl[k].npush; j++) qa.push_back(tbl[k].pw + 32'(j));
                    empty_a = 1'b0;
                end
                oready_a = tbl[k].rdy;
                flush_a  = tbl[k].fl;
                #1;
                chk_out($sformatf("vec%0d_%0d", k, r), rd_en_a, ovalid_a, odata_a, ocount_a,
                        tbl[k].re, tbl[k].v, tbl[k].d, tbl[k].c);
                tick();
            end
        end
        flush_a = 1'b0;

        // DEPTH=3: simultaneous capture and pop at count=2 with pointer wrap
        for (int j = 0; j < 8; j++) qb.push_back(32'h20 + 32'(j));
        empty_b = 1'b0;
        bstep("wrap0", 0, 1, 0, 32'h0, 0);
        bstep("wrap1", 0, 1, 0, 32'h0, 0);
        bstep("wrap2", 0, 1, 1, 32'h20, 1);
        for (int j = 0; j < 5; j++) bstep($sformatf("wrap%0d", 3 + j), 1, 1, 1, 32'h20 + 32'(j), 2);
        bstep("wrap8", 1, 0, 1, 32'h25, 2);
        bstep("wrap9", 1, 0, 1, 32'h26, 2);
        bstep("wrap10", 1, 0, 1, 32'h27, 1);
        bstep("wrap11", 1, 0, 0, 32'h0, 0);

        // DEPTH=3: reset with count=2 and a read in flight
        for (int j = 0; j < 4; j++) qb.push_back(32'h30 + 32'(j));
        empty_b = 1'b0;
        bstep("mrst0", 0, 1, 0, 32'h0, 0);
        bstep("mrst1", 0, 1, 0, 32'h0, 0);
        bstep("mrst2", 0, 1, 1, 32'h30, 1);
        #1;
        chk_out("mrst3", rd_en_b, ovalid_b, odata_b, ocount_b, 0, 1, 32'h30, 2);
        rst_b = 1'b0;
        #1;
        chk_out("mrst_low", rd_en_b, ovalid_b, odata_b, ocount_b, 0, 0, 32'h0, 0);
        chk("mrst_low_data", odata_b, 32'h0);
        qb.delete();
        empty_b = 1'b1;
        tick();
        #1;
        chk_out("mrst_held", rd_en_b, ovalid_b, odata_b, ocount_b, 0, 0, 32'h0, 0);
        rst_b = 1'b1;
        qb.push_back(32'hA5);
        empty_b = 1'b0;
        #1;
        chk_out("mrst_release", rd_en_b, ovalid_b, odata_b, ocount_b, 0, 0, 32'h0, 0);
        tick();
        bstep("mrst_x1", 1, 1, 0, 32'h0, 0);
        bstep("mrst_x2", 1, 0, 0, 32'h0, 0);
        bstep("mrst_x3", 1, 0, 1, 32'hA5, 1);
        bstep("mrst_x4", 1, 0, 0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
